// File: rtl/st_channel_arbiter_if.sv
// Handshake bundle for st_channel_arbiter: NUM_CH input streams, their enables and the merged
// output source. The arbiter uses the slave view; the traffic environment uses the master view.
interface st_channel_arbiter_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        ch_enable;
  logic [DATA_W-1:0]        data_source_data;
  logic [CH_W-1:0]          data_source_channel;
  logic                     data_source_valid;
  logic                     data_source_ready;

  modport slave (
    input  in_data, in_valid, ch_enable, data_source_ready,
    output in_ready, data_source_data, data_source_channel, data_source_valid
  );

  modport master (
    output in_data, in_valid, ch_enable, data_source_ready,
    input  in_ready, data_source_data, data_source_channel, data_source_valid
  );
endinterface

// File: rtl/st_channel_arbiter.sv
// Burst round-robin merge of NUM_CH streams into one show-ahead output FIFO that tags each beat
// with its source channel. One IDLE cycle separates consecutive grants.
module st_channel_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                kernel_clk_clk,
  input  logic                kernel_reset_reset,
  st_channel_arbiter_if.slave bus,
  output logic [LVL_W-1:0]    fifo_level
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CW1    = CH_W + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_cur, w_cur_nxt;
  logic [CH_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BCNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]   r_mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic [NUM_CH-1:0] w_req;
  logic              w_req_any;
  logic [CH_W-1:0]   w_grant;
  logic [CW1-1:0]    w_sum;
  logic [CH_W-1:0]   w_idx;
  logic              w_cur_valid, w_cur_en;
  logic [DATA_W-1:0] w_cur_data;
  logic [NUM_CH-1:0] w_ready;
  logic              w_full, w_accept, w_pop, w_out_valid;

  assign w_req = bus.in_valid & bus.ch_enable;

  // Scan from highest index down so the last hit is the one nearest rr_ptr+1.
  always_comb begin
    w_req_any = 1'b0;
    w_grant   = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = int'(NUM_CH); k >= 1; k--) begin
      w_sum = {1'b0, r_rr_ptr} + CW1'(k);
      w_idx = (w_sum >= CW1'(NUM_CH)) ? CH_W'(w_sum - CW1'(NUM_CH)) : CH_W'(w_sum);
      if (w_req[w_idx]) begin
        w_req_any = 1'b1;
        w_grant   = w_idx;
      end
    end
  end

  always_comb begin
    w_cur_valid = 1'b0;
    w_cur_en    = 1'b0;
    w_cur_data  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (r_cur == CH_W'(c)) begin
        w_cur_valid = bus.in_valid[c];
        w_cur_en    = bus.ch_enable[c];
        w_cur_data  = bus.in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign w_full = (r_level == LVL_FULL);

  always_comb begin
    w_ready = '0;
    if (!kernel_reset_reset && r_state == StServe && !w_full && w_cur_en) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (r_cur == CH_W'(c)) w_ready[c] = 1'b1;
      end
    end
  end

  assign w_accept    = |(w_ready & bus.in_valid);
  assign w_out_valid = !kernel_reset_reset && (r_level != '0);
  assign w_pop       = w_out_valid && bus.data_source_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req_any) begin
          w_state_nxt    = StServe;
          w_cur_nxt      = w_grant;
          w_rr_ptr_nxt   = w_grant;
          w_beat_cnt_nxt = '0;
        end
      end
      StServe: begin
        if (w_accept) w_beat_cnt_nxt = r_beat_cnt + BCNT_W'(1);
        // A full FIFO with valid and enable still high holds the grant.
        if ((w_accept && r_beat_cnt == BCNT_LAST) || !w_cur_valid || !w_cur_en) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (kernel_reset_reset) begin
      r_state    <= StIdle;
      r_cur      <= '0;
      r_rr_ptr   <= CH_W'(NUM_CH - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (kernel_reset_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_accept && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_accept && w_pop) r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (w_accept) begin
      r_mem_data[r_wr_ptr] <= w_cur_data;
      r_mem_ch[r_wr_ptr]   <= r_cur;
    end
  end

  assign bus.in_ready            = w_ready;
  assign bus.data_source_valid   = w_out_valid;
  assign bus.data_source_data    = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.data_source_channel = w_out_valid ? r_mem_ch[r_rd_ptr] : '0;
  assign fifo_level              = kernel_reset_reset ? '0 : r_level;
endmodule

// File: tb/tb_st_channel_arbiter.sv
// Randomised and directed bench for st_channel_arbiter against a queue-based reference model.
module tb_st_channel_arbiter;
  localparam int DATA_W     = 64;
  localparam int NUM_CH     = 4;
  localparam int BURST_LEN  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;
  localparam int LVL_W      = 3;

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [LVL_W-1:0] fifo_level;

  st_channel_arbiter_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  st_channel_arbiter #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .BURST_LEN (BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .kernel_clk_clk    (clk),
    .kernel_reset_reset(rst),
    .bus               (bus),
    .fifo_level        (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the grant, beats taken in this burst, and the FIFO contents.
  bit              m_serving;
  logic [CH_W-1:0] m_cur;
  logic [CH_W-1:0] m_rr;
  int              m_taken;
  beat_t           m_q[$];
  int              pop_ch[$];
  logic [55:0]     src_seq[NUM_CH];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] e_ready;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic [CH_W-1:0]   e_ch;
    logic [CH_W-1:0]   c;
    int                lvl;
    bit                acc;
    bit                pop;
    lvl     = m_q.size();
    e_ready = '0;
    if (!rst && m_serving && lvl < FIFO_DEPTH && bus.ch_enable[m_cur]) e_ready[m_cur] = 1'b1;
    e_valid = !rst && lvl != 0;
    e_data  = e_valid ? m_q[0].data : '0;
    e_ch    = e_valid ? m_q[0].ch : '0;
    chk("in_ready", 64'(bus.in_ready), 64'(e_ready));
    chk("out_valid", 64'(bus.data_source_valid), 64'(e_valid));
    chk("out_data", bus.data_source_data, e_data);
    chk("out_channel", 64'(bus.data_source_channel), 64'(e_ch));
    chk("fifo_level", 64'(fifo_level), rst ? 64'd0 : 64'(lvl));
    if (rst) begin
      m_serving = 1'b0;
      m_rr      = CH_W'(NUM_CH - 1);
      m_cur     = '0;
      m_taken   = 0;
      m_q.delete();
      return;
    end
    acc = e_ready[m_cur] && bus.in_valid[m_cur];
    pop = e_valid && bus.data_source_ready;
    if (pop) begin
      pop_ch.push_back(int'(e_ch));
      void'(m_q.pop_front());
    end
    if (acc) begin
      m_q.push_back('{ch: m_cur, data: bus.in_data[int'(m_cur)*DATA_W +: DATA_W]});
      src_seq[m_cur] = src_seq[m_cur] + 56'd1;
    end
    if (!m_serving) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = CH_W'((int'(m_rr) + k) % NUM_CH);
        if (bus.in_valid[c] && bus.ch_enable[c]) begin
          m_serving = 1'b1;
          m_cur     = c;
          m_rr      = c;
          m_taken   = 0;
          break;
        end
      end
    end else begin
      if (acc) m_taken++;
      if ((acc && m_taken == BURST_LEN) || !bus.in_valid[m_cur] || !bus.ch_enable[m_cur])
        m_serving = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    for (int c = 0; c < NUM_CH; c++) bus.in_data[c*DATA_W +: DATA_W] = {8'(c), src_seq[c]};
  endtask

  task automatic do_reset();
    rst                   = 1'b1;
    bus.in_valid          = '0;
    bus.ch_enable         = '0;
    bus.data_source_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int exp_order[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
  int          n_win;
  int          cnt2;
  int          rdy_pct;
  logic [55:0] base;

  initial begin
    rst                   = 1'b1;
    bus.in_data           = '0;
    bus.in_valid          = '0;
    bus.ch_enable         = '0;
    bus.data_source_ready = 1'b0;
    m_serving = 1'b0;
    m_cur     = '0;
    m_rr      = CH_W'(NUM_CH - 1);
    m_taken   = 0;
    for (int c = 0; c < NUM_CH; c++) src_seq[c] = '0;

    // Single channel, three literal beats.
    do_reset();
    bus.in_valid = 4'b0001; bus.ch_enable = '1; bus.data_source_ready = 1'b1;
    bus.in_data = '0; bus.in_data[63:0] = 64'hA0;
    #1;
    chk("post_reset_ready", 64'(bus.in_ready), 64'd0);
    chk("post_reset_valid", 64'(bus.data_source_valid), 64'd0);
    chk("post_reset_data", bus.data_source_data, 64'd0);
    chk("post_reset_level", 64'(fifo_level), 64'd0);
    cycle();
    #1;
    chk("a_grant_ready", 64'(bus.in_ready), 64'd1);
    chk("a_no_out_yet", 64'(bus.data_source_valid), 64'd0);
    cycle();
    bus.in_data[63:0] = 64'hA1; #1;
    chk("a_out0", bus.data_source_data, 64'hA0);
    chk("a_out0_ch", 64'(bus.data_source_channel), 64'd0);
    cycle();
    bus.in_data[63:0] = 64'hA2; #1;
    chk("a_out1", bus.data_source_data, 64'hA1);
    cycle();
    bus.in_valid = '0; #1;
    chk("a_out2", bus.data_source_data, 64'hA2);
    cycle();
    #1;
    chk("a_idle_ready", 64'(bus.in_ready), 64'd0);
    chk("a_drained", 64'(fifo_level), 64'd0);

    // All channels busy: burst order and one bubble per switch.
    do_reset();
    pop_ch.delete();
    n_win = 0;
    for (int i = 0; i < 25; i++) begin
      bus.in_valid = '1; bus.ch_enable = '1; bus.data_source_ready = 1'b1;
      drive_src();
      if (i == 21) n_win = pop_ch.size();
      cycle();
    end
    chk("b_pops_in_21_cycles", 64'(n_win), 64'd16);
    if (pop_ch.size() < 17) chk("b_pop_count", 64'(pop_ch.size()), 64'd17);
    else for (int i = 0; i < 17; i++) chk("b_order", 64'(pop_ch[i]), 64'(exp_order[i]));

    // Backpressure fills the FIFO, then drains and resumes.
    do_reset();
    base = src_seq[1];
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 4'b0010; bus.ch_enable = '1; bus.data_source_ready = 1'b0;
      drive_src();
      cycle();
    end
    drive_src(); #1;
    chk("c_level_full", 64'(fifo_level), 64'd4);
    chk("c_ready_gated", 64'(bus.in_ready), 64'd0);
    chk("c_head_data", bus.data_source_data, {8'd1, base});
    bus.data_source_ready = 1'b1;
    cycle();
    drive_src(); #1;
    chk("c_resume_ready", 64'(bus.in_ready), 64'd2);
    for (int i = 0; i < 15; i++) begin drive_src(); cycle(); end

    // Disabled channel never granted; enable drop releases mid-burst.
    do_reset();
    bus.in_valid = 4'b1101; bus.ch_enable = 4'b1011; bus.data_source_ready = 1'b1;
    drive_src(); cycle();
    drive_src(); cycle();
    bus.ch_enable = 4'b1010; drive_src(); #1;
    chk("d_en_drop_same_cycle", 64'(bus.in_ready), 64'd0);
    cycle();
    drive_src(); #1;
    chk("d_released_idle", 64'(bus.in_ready), 64'd0);
    cycle();
    drive_src(); #1;
    chk("d_next_grant_ch3", 64'(bus.in_ready), 64'h8);
    cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      bus.ch_enable = {1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      bus.data_source_ready = 1'($urandom_range(0, 1));
      drive_src(); #1;
      if (bus.in_ready[2]) cnt2++;
      cycle();
    end
    chk("d_ch2_never_ready", 64'(cnt2), 64'd0);

    // Reset with three beats held mid-burst.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 4'b0001; bus.ch_enable = '1; bus.data_source_ready = 1'b0;
      drive_src(); cycle();
    end
    drive_src(); #1;
    chk("e_level_3", 64'(fifo_level), 64'd3);
    rst = 1'b1; #1;
    chk("e_during_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("e_during_rst_valid", 64'(bus.data_source_valid), 64'd0);
    cycle();
    rst = 1'b0; bus.in_valid = 4'b1010; bus.data_source_ready = 1'b1; drive_src(); #1;
    chk("e_after_rst_level", 64'(fifo_level), 64'd0);
    chk("e_after_rst_valid", 64'(bus.data_source_valid), 64'd0);
    chk("e_after_rst_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    drive_src(); #1;
    chk("e_lowest_grant", 64'(bus.in_ready), 64'd2);
    cycle();

    // Random traffic, enables, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 500) % 2 == 1) ? 30 : 90;
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        bus.in_valid[c]  = ($urandom_range(0, 99) < 80);
        bus.ch_enable[c] = ($urandom_range(0, 99) < 90);
      end
      bus.data_source_ready = ($urandom_range(0, 99) < rdy_pct);
      drive_src();
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
